result_drain: RTL and testbench

- Output stage directly downstream of the matrix-vector compute top.
- Snapshots the ROWS×ACC_W accumulator vector (result_flat) on a capture pulse.
- Requantises each row: rounding arithmetic right shift, then saturation to DW bits.
- Streams the rows out one per handshake over a valid/ready interface, row 0 first, and flags captures lost while busy.

---
 rtl/result_drain.sv | 155 +++++++++++++++
 tb/tb_result_drain.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// Module      : result_drain
// Description : Snapshots the accumulator vector on capture, requantises each
//               row (round-half-up shift + saturate) and streams rows out.
// Revision    : 1.0 - initial release
// ============================================================================
module result_drain #(
    parameter int DW    = 8,
    parameter int ROWS  = 12,
    parameter int ACC_W = 16,
    parameter int ROW_W = 4,
    parameter int SH_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic [ROWS*ACC_W-1:0] result_flat,
    input  logic [SH_W-1:0]       shift,
    input  logic                  clr_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [ROW_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [ROW_W-1:0]       c_last_idx = ROW_W'(ROWS - 1);
    localparam logic signed [ACC_W:0]  c_sat_max  = (ACC_W+1)'(2**(DW-1) - 1);
    localparam logic signed [ACC_W:0]  c_sat_min  = ~c_sat_max;
    localparam logic signed [ACC_W:0]  c_one      = (ACC_W+1)'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ROW_W-1:0]        r_idx;
    logic [ROW_W-1:0]        w_idx_nxt;
    logic [SH_W-1:0]         r_shift;
    logic                    r_overrun;
    logic                    w_load;
    logic                    w_ovr_set;
    logic                    w_drain;
    logic                    w_is_last;
    logic signed [ACC_W-1:0] r_snap [ROWS];
    logic signed [ACC_W-1:0] w_rows [ROWS];
    logic signed [ACC_W:0]   w_val;
    logic signed [ACC_W:0]   w_rnd;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W:0]   w_q;
    logic [DW-1:0]           w_data;

    generate
        for (genvar g = 0; g < ROWS; g++) begin : g_unpack
            assign w_rows[g] = result_flat[g*ACC_W +: ACC_W];
        end
    endgenerate

    assign w_drain   = (r_state == ST_DRAIN);
    assign w_is_last = (r_idx == c_last_idx);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (capture) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready && w_is_last) begin
                    // A capture on the final handshake starts the next vector with no bubble
                    w_idx_nxt = '0;
                    if (capture) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    if (out_ready) begin
                        w_idx_nxt = r_idx + ROW_W'(1);
                    end
                    w_ovr_set = capture;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_shift   <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_load) begin
                r_shift <= shift;
                for (int i = 0; i < ROWS; i++) begin
                    r_snap[i] <= w_rows[i];
                end
            end
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping
    always_comb begin
        w_val = {r_snap[r_idx][ACC_W-1], r_snap[r_idx]};
        w_rnd = '0;
        if (r_shift != '0) begin
            w_rnd = c_one <<< (r_shift - SH_W'(1));
        end
        w_sum = w_val + w_rnd;
        w_q   = w_sum >>> r_shift;
        if (w_q > c_sat_max) begin
            w_data = c_sat_max[DW-1:0];
        end else if (w_q < c_sat_min) begin
            w_data = c_sat_min[DW-1:0];
        end else begin
            w_data = w_q[DW-1:0];
        end
    end

    assign out_valid = w_drain;
    assign busy      = w_drain;
    assign out_idx   = w_drain ? r_idx : '0;
    assign out_last  = w_drain && w_is_last;
    assign out_data  = w_drain ? w_data : '0;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_drain
// Description : Directed, table-driven bench for result_drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_drain;

    localparam int DW    = 8;
    localparam int ROWS  = 12;
    localparam int ACC_W = 16;
    localparam int ROW_W = 4;
    localparam int SH_W  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  capture = 1'b0;
    logic                  clr_err = 1'b0;
    logic                  out_ready = 1'b0;
    logic [ROWS*ACC_W-1:0] result_flat = '0;
    logic [SH_W-1:0]       shift = '0;
    logic                  out_valid;
    logic                  out_last;
    logic                  busy;
    logic                  overrun;
    logic [DW-1:0]         out_data;
    logic [ROW_W-1:0]      out_idx;

    result_drain #(
        .DW(DW), .ROWS(ROWS), .ACC_W(ACC_W), .ROW_W(ROW_W), .SH_W(SH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .capture(capture), .result_flat(result_flat),
        .shift(shift), .clr_err(clr_err), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SH_W-1:0]         sh;
        logic signed [ACC_W-1:0] v;
        logic signed [DW-1:0]    exp;
    } vec_t;

    vec_t tbl [36];
    int   n_tbl = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(int sh, int v, int e);
        tbl[n_tbl].sh  = SH_W'(sh);
        tbl[n_tbl].v   = ACC_W'(v);
        tbl[n_tbl].exp = DW'(e);
        n_tbl++;
    endfunction

    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_group(int g);
        for (int r = 0; r < ROWS; r++) begin
            result_flat[r*ACC_W +: ACC_W] = tbl[g*ROWS + r].v;
        end
        shift = tbl[g*ROWS].sh;
    endtask

    task automatic capture_group(int g);
        set_group(g);
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
    endtask

    // Drains rows first..last of group g; optional random stalls, input
    // scrambling, and a capture of next_g on the final handshake.
    task automatic drain(int g, int first, int last, bit rnd, bit scram, int next_g);
        int stalls;
        bit rdy;
        for (int r = first; r <= last; r++) begin
            stalls = 0;
            do begin
                rdy = rnd ? (($urandom_range(0, 1) == 1) || (stalls >= 4)) : 1'b1;
                out_ready = rdy;
                chk("valid", out_valid, 1);
                chk("busy", busy, 1);
                chk("idx", out_idx, r);
                chk("data", $signed(out_data), tbl[g*ROWS + r].exp);
                chk("last", out_last, (r == ROWS-1));
                if (scram) begin
                    result_flat = {6{$urandom()}};
                    shift       = SH_W'($urandom());
                end
                if (rdy && r == last && next_g >= 0) begin
                    set_group(next_g);
                    capture = 1'b1;
                end
                @(negedge clk);
                capture = 1'b0;
                stalls++;
            end while (!rdy);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Group 0: shift 0, plain saturation
        add(0, 100, 100);  add(0, 300, 127);  add(0, -300, -128); add(0, 127, 127);
        add(0, -128, -128); add(0, 0, 0);     add(0, 0, 0);       add(0, 0, 0);
        add(0, 0, 0);      add(0, 0, 0);      add(0, 0, 0);       add(0, 0, 0);
        // Group 1: shift 4, rounding half-up then saturation
        add(4, 40, 3);     add(4, -40, -2);   add(4, 7, 0);       add(4, 8, 1);
        add(4, -8, 0);     add(4, 32767, 127); add(4, -32768, -128); add(4, 24, 2);
        add(4, -24, -1);   add(4, -9, -1);    add(4, 23, 1);      add(4, 0, 0);
        // Group 2: shift 15, rounding add at the edge of the accumulator range
        add(15, 16384, 1); add(15, 32767, 1); add(15, -32768, -1); add(15, -16384, 0);
        add(15, 16383, 0); add(15, -16385, -1); add(15, 0, 0);    add(15, 0, 0);
        add(15, 0, 0);     add(15, 0, 0);     add(15, 0, 0);      add(15, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", out_valid, 0);

        // Basic drains at full throughput
        capture_group(0);
        drain(0, 0, ROWS-1, 1'b0, 1'b0, -1);
        chk("end0_valid", out_valid, 0);
        chk("end0_busy", busy, 0);
        capture_group(1);
        drain(1, 0, ROWS-1, 1'b0, 1'b0, -1);
        chk("end1_valid", out_valid, 0);

        // Random backpressure
        capture_group(1);
        drain(1, 0, ROWS-1, 1'b1, 1'b0, -1);
        chk("end_rnd_valid", out_valid, 0);

        // Inputs churn during the drain; only the snapshot matters
        capture_group(2);
        drain(2, 0, ROWS-1, 1'b1, 1'b1, -1);
        chk("end_scr_valid", out_valid, 0);

        // Dropped capture mid-drain
        capture_group(0);
        drain(0, 0, 4, 1'b0, 1'b0, -1);
        set_group(1);
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        chk("ovr_set", overrun, 1);
        drain(0, 5, ROWS-1, 1'b0, 1'b0, -1);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_idle", out_valid, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Set wins over clear, then back-to-back capture on the final handshake
        capture_group(0);
        drain(0, 0, 2, 1'b0, 1'b0, -1);
        capture = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        clr_err = 1'b0;
        chk("ovr_setwins", overrun, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovr_clr2", overrun, 0);
        drain(0, 3, ROWS-1, 1'b0, 1'b0, 1);
        chk("b2b_ovr", overrun, 0);
        drain(1, 0, ROWS-1, 1'b0, 1'b0, -1);
        chk("b2b_end", out_valid, 0);

        // Reset in the middle of a drain
        capture_group(0);
        drain(0, 0, 6, 1'b0, 1'b0, -1);
        chk("pre_rst_idx", out_idx, 7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_idx", out_idx, 0);
        chk("mid_rst_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
